clock_seg_disp: RTL and testbench

//  - Display end of the clock time interface: consumes hour/minu/seco and their *_vld strobes from the clock core.
//  - Drives a 6-digit multiplexed common-anode 7-segment display as HH MM SS.
//  - Latches each field on its strobe, splits it into BCD digits and time-multiplexes the digits with inter-slot blanking.

---
 rtl/clock_disp_pkg.sv | 18 +
 rtl/bin2bcd_6b.sv | 35 +++
 rtl/clock_seg_disp.sv | 111 +++++++++++
 tb/tb_clock_seg_disp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared constants, 7-segment font and range limits for the clock display.
package clock_disp_pkg;

    localparam int          DIG_NUM    = 6;
    localparam logic [7:0]  SEG_OFF    = 8'hFF;
    localparam logic [5:0]  SEL_OFF    = 6'h3F;
    localparam logic [5:0]  HOUR_MAX   = 6'd23;
    localparam logic [5:0]  MINSEC_MAX = 6'd59;

    // Active-low g..a with dp off; FONT[n] is the glyph for decimal digit n.
    localparam logic [9:0][7:0] FONT = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

    function automatic logic [7:0] font(input logic [3:0] d);
        font = (d < 4'd10) ? FONT[d] : SEG_OFF;
    endfunction

endpackage

// File: rtl/bin2bcd_6b.sv
// rtl/bin2bcd_6b.sv - combinational 6-bit binary to two BCD digits by compare/subtract.
module bin2bcd_6b (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [5:0] rem;

    always_comb begin
        tens = 4'd0;
        rem  = bin;
        if (bin >= 6'd60) begin
            tens = 4'd6;
            rem  = bin - 6'd60;
        end else if (bin >= 6'd50) begin
            tens = 4'd5;
            rem  = bin - 6'd50;
        end else if (bin >= 6'd40) begin
            tens = 4'd4;
            rem  = bin - 6'd40;
        end else if (bin >= 6'd30) begin
            tens = 4'd3;
            rem  = bin - 6'd30;
        end else if (bin >= 6'd20) begin
            tens = 4'd2;
            rem  = bin - 6'd20;
        end else if (bin >= 6'd10) begin
            tens = 4'd1;
            rem  = bin - 6'd10;
        end
        units = 4'(rem);
    end

endmodule

// File: rtl/clock_seg_disp.sv
// rtl/clock_seg_disp.sv - HH MM SS multiplexed common-anode 7-segment driver with slot blanking.
// Optional CLOCK_SEG_DISP_DP_BLINK_EN toggles the dp on digits 1 and 3 per accepted second.
import clock_disp_pkg::*;

module clock_seg_disp #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int BLANK_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] hour,
    input  logic [5:0] minu,
    input  logic [5:0] seco,
    input  logic       hour_vld,
    input  logic       minu_vld,
    input  logic       seco_vld,
    output logic [7:0] seg,
    output logic [5:0] sel
);

    localparam int SLOT_CYC = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       DIG_LAST  = 3'(DIG_NUM - 1);

    logic [5:0]       hour_r, minu_r, seco_r;
    logic [CNT_W-1:0] slot_cnt;
    logic [2:0]       dig_idx;
    logic [3:0]       hour_t, hour_u, minu_t, minu_u, seco_t, seco_u;
    logic [3:0]       digit;
    logic [7:0]       seg_nxt;
    logic [5:0]       sel_nxt;

    // Out-of-range values are dropped so the display never shows an impossible time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_r <= '0;
            minu_r <= '0;
            seco_r <= '0;
        end else begin
            if (hour_vld && (hour <= HOUR_MAX))   hour_r <= hour;
            if (minu_vld && (minu <= MINSEC_MAX)) minu_r <= minu;
            if (seco_vld && (seco <= MINSEC_MAX)) seco_r <= seco;
        end
    end

`ifdef CLOCK_SEG_DISP_DP_BLINK_EN
    logic dp_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dp_state <= 1'b0;
        else if (seco_vld && (seco <= MINSEC_MAX))
            dp_state <= ~dp_state;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == DIG_LAST) ? 3'd0 : dig_idx + 3'd1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    bin2bcd_6b u_hour_bcd (.bin(hour_r), .tens(hour_t), .units(hour_u));
    bin2bcd_6b u_minu_bcd (.bin(minu_r), .tens(minu_t), .units(minu_u));
    bin2bcd_6b u_seco_bcd (.bin(seco_r), .tens(seco_t), .units(seco_u));

    always_comb begin
        digit = 4'd0;
        case (dig_idx)
            3'd0:    digit = hour_t;
            3'd1:    digit = hour_u;
            3'd2:    digit = minu_t;
            3'd3:    digit = minu_u;
            3'd4:    digit = seco_t;
            3'd5:    digit = seco_u;
            default: digit = 4'd0;
        endcase
    end

    always_comb begin
        seg_nxt = SEG_OFF;
        sel_nxt = SEL_OFF;
        if (slot_cnt >= BLANK_END) begin
            sel_nxt = ~(6'b000001 << dig_idx);
            seg_nxt = font(digit);
`ifdef CLOCK_SEG_DISP_DP_BLINK_EN
            seg_nxt[7] = ((dig_idx == 3'd1) || (dig_idx == 3'd3)) ? ~dp_state : 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            sel <= SEL_OFF;
        end else begin
            seg <= seg_nxt;
            sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_clock_seg_disp.sv
// tb/tb_clock_seg_disp.sv - self-checking bench for clock_seg_disp with a cycle-level time model.
module tb_clock_seg_disp;

    localparam int SLOT  = 12;
    localparam int BLANK = 2;
    localparam int FRAME = SLOT * 6;
`ifdef CLOCK_SEG_DISP_DP_BLINK_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] hour, minu, seco;
    logic       hour_vld, minu_vld, seco_vld;
    logic [7:0] seg;
    logic [5:0] sel;

    always #5 clk = ~clk;

    clock_seg_disp #(.CLK_FREQ(12_000), .SCAN_HZ(1_000), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst(rst),
        .hour(hour), .minu(minu), .seco(seco),
        .hour_vld(hour_vld), .minu_vld(minu_vld), .seco_vld(seco_vld),
        .seg(seg), .sel(sel)
    );

    logic [7:0] font_t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    typedef struct {
        logic [5:0]  h, m, s;
        logic [2:0]  vld;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [7];

    int   checks = 0;
    int   errors = 0;
    int   m_t, m_h, m_m, m_s;
    bit   m_dp;
    logic [7:0] exp_seg;
    logic [5:0] exp_sel;
    logic [7:0] rec [6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %02h want %02h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_h = 0; m_m = 0; m_s = 0; m_dp = 1'b0;
    endtask

    // Expected outputs after this edge come from the counter value and shadows held before it.
    task automatic model_edge();
        int cnt, d, val;
        cnt = m_t % SLOT;
        d   = (m_t / SLOT) % 6;
        case (d)
            0: val = m_h / 10;
            1: val = m_h % 10;
            2: val = m_m / 10;
            3: val = m_m % 10;
            4: val = m_s / 10;
            default: val = m_s % 10;
        endcase
        if (cnt < BLANK) begin
            exp_seg = 8'hFF;
            exp_sel = 6'h3F;
        end else begin
            exp_sel = 6'h3F & ~(6'd1 << d);
            exp_seg = font_t[val];
            if (DP_EN && (d == 1 || d == 3)) exp_seg[7] = ~m_dp;
        end
        if (hour_vld && hour <= 23) m_h = int'(hour);
        if (minu_vld && minu <= 59) m_m = int'(minu);
        if (seco_vld && seco <= 59) begin
            m_s = int'(seco);
            if (DP_EN) m_dp = ~m_dp;
        end
        m_t++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("seg_model", seg, exp_seg);
        check("sel_model", {2'b00, sel}, {2'b00, exp_sel});
        hour_vld = 1'b0;
        minu_vld = 1'b0;
        seco_vld = 1'b0;
    endtask

    task automatic run_to(input int pos, input string name);
        int n;
        n = 0;
        while ((m_t % FRAME) != pos && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout: got pos %0d want %0d", name, m_t % FRAME, pos);
        end
    endtask

    initial begin
        vecs[0] = '{6'd23, 6'd45, 6'd7,  3'b111, 48'hA4B0_9992_C0F8};
        vecs[1] = '{6'd24, 6'd60, 6'd7,  3'b110, 48'hA4B0_9992_C0F8};
        vecs[2] = '{6'd12, 6'd34, 6'd56, 3'b111, 48'hF9A4_B099_9282};
        vecs[3] = '{6'd0,  6'd0,  6'd0,  3'b100, 48'hC0C0_B099_9282};
        vecs[4] = '{6'd9,  6'd59, 6'd60, 3'b011, 48'hC0C0_9290_9282};
        vecs[5] = '{6'd23, 6'd0,  6'd59, 3'b111, 48'hA4B0_C0C0_9290};
        vecs[6] = '{6'd23, 6'd45, 6'd7,  3'b111, 48'hA4B0_9992_C0F8};

        rst = 1'b1;
        hour = '0; minu = '0; seco = '0;
        hour_vld = 1'b0; minu_vld = 1'b0; seco_vld = 1'b0;
        model_reset();

        // Reset state and first slot after release.
        #3;
        check("reset_seg", seg, 8'hFF);
        check("reset_sel", {2'b00, sel}, 8'h3F);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        step();
        check("first_digit_seg", seg, 8'hC0);
        check("first_digit_sel", {2'b00, sel}, 8'h3E);

        // Table: load, then scan a full frame and record each digit's glyph.
        for (int v = 0; v < 7; v++) begin
            hour = vecs[v].h; minu = vecs[v].m; seco = vecs[v].s;
            hour_vld = vecs[v].vld[2];
            minu_vld = vecs[v].vld[1];
            seco_vld = vecs[v].vld[0];
            step();
            for (int k = 0; k < 6; k++) rec[k] = 8'h00;
            for (int c = 0; c < FRAME + 2; c++) begin
                step();
                for (int k = 0; k < 6; k++)
                    if (sel == (6'h3F & ~(6'd1 << k))) rec[k] = seg;
            end
            for (int k = 0; k < 6; k++)
                check($sformatf("vec%0d_dig%0d", v, k), rec[k] & 8'h7F,
                      vecs[v].exp[47 - 8*k -: 8] & 8'h7F);
        end

        // Mid-slot update on seconds units.
        run_to(5 * SLOT + 6, "mid");
        seco = 6'd8;
        seco_vld = 1'b1;
        step();
        check("mid_hold_seg", seg, 8'hF8);
        check("mid_hold_sel", {2'b00, sel}, 8'h1F);
        step();
        check("mid_upd_seg", seg, 8'h80);
        check("mid_upd_sel", {2'b00, sel}, 8'h1F);

        // Asynchronous reset in the middle of slot 3.
        run_to(3 * SLOT + 6, "areset");
        #2;
        rst = 1'b1;
        #1;
        check("areset_seg", seg, 8'hFF);
        check("areset_sel", {2'b00, sel}, 8'h3F);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        step();
        check("areset_dig0_seg", seg, 8'hC0);
        check("areset_dig0_sel", {2'b00, sel}, 8'h3E);

        // Decimal-point blink on digits 1 and 3.
        seco = 6'd1;
        seco_vld = 1'b1;
        step();
        run_to(SLOT + 6, "dp1");
        check("dp_first_d1", {7'd0, seg[7]}, {7'd0, ~DP_EN});
        run_to(3 * SLOT + 6, "dp1b");
        check("dp_first_d3", {7'd0, seg[7]}, {7'd0, ~DP_EN});
        seco = 6'd2;
        seco_vld = 1'b1;
        step();
        run_to(3 * SLOT + 6, "dp2");
        check("dp_second_d3", {7'd0, seg[7]}, 8'h01);

        // Random strobes, including out-of-range values.
        for (int i = 0; i < 400; i++) begin
            hour = 6'($urandom_range(0, 63));
            minu = 6'($urandom_range(0, 63));
            seco = 6'($urandom_range(0, 63));
            hour_vld = ($urandom_range(0, 3) == 0);
            minu_vld = ($urandom_range(0, 3) == 0);
            seco_vld = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
